// File: rtl/param_stim_gen.sv
// param_stim_gen: walks a BSIZE-bit stimulus value from 0 to LAST. Each value
// is held for HOLD unpaused cycles, then a one-cycle done pulse is emitted.
// Optional build macro: PARAM_STIM_GRAY_EN. When it is defined, stim carries
// the Gray-coded count instead of the plain binary count.
//
// Output semantics: stim is meaningful only while valid is high. There is no
// back-pressure; the consumer must accept stim on every cycle that valid is
// asserted. done pulses once, in the cycle after the last valid cycle.
module param_stim_gen #(
    parameter int BSIZE = 2,
    parameter int HOLD  = 5,
    parameter int LAST  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    output logic [BSIZE-1:0] stim,
    output logic             valid,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // The hold counter needs to count 0..HOLD-1. It is always at least 1 bit wide.
    localparam int HW = (HOLD + 1 > 2) ? $clog2(HOLD + 1) : 1;
    localparam logic [HW-1:0]    HOLD_END = HW'(HOLD - 1);
    localparam logic [BSIZE-1:0] CNT_END  = BSIZE'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [BSIZE-1:0] cnt, cnt_nxt;
    logic [HW-1:0]    hcnt, hcnt_nxt;
    logic [BSIZE-1:0] stim_nxt;
    logic             valid_nxt;
    logic             done_nxt;

    assign state_dbg = state;

    // Maps the value counter onto the bus encoding.
    function automatic logic [BSIZE-1:0] stim_map(input logic [BSIZE-1:0] c);
`ifdef PARAM_STIM_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    // Next-state logic. All outputs are computed one cycle ahead so that
    // they can be registered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hcnt_nxt  = hcnt;
        stim_nxt  = stim;
        valid_nxt = valid;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    hcnt_nxt  = '0;
                    stim_nxt  = stim_map('0);
                    valid_nxt = 1'b1;
                end
            end
            RUN: begin
                valid_nxt = 1'b1;
                if (!pause) begin
                    if (hcnt == HOLD_END) begin
                        if (cnt == CNT_END) begin
                            // The final hold has completed. stim keeps its last value.
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            cnt_nxt  = cnt + BSIZE'(1);
                            hcnt_nxt = '0;
                            stim_nxt = stim_map(cnt + BSIZE'(1));
                        end
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. The reset is asynchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
            stim  <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hcnt  <= hcnt_nxt;
            stim  <= stim_nxt;
            valid <= valid_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_param_stim_gen.sv
// Testbench for param_stim_gen with BSIZE=2, HOLD=5, LAST=2.
// The expected per-cycle trace is built from the sequencing rules before each
// run. Value k is shown until HOLD unpaused cycles have elapsed on it.
module tb_param_stim_gen;

    localparam int BSIZE = 2;
    localparam int HOLD  = 5;
    localparam int LAST  = 2;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             pause;
    logic [BSIZE-1:0] stim;
    logic             valid;
    logic             done;
    logic [1:0]       state_dbg;

    int n_checks;
    int n_fail;
    logic [BSIZE-1:0] idle_stim;

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    param_stim_gen #(.BSIZE(BSIZE), .HOLD(HOLD), .LAST(LAST)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .pause     (pause),
        .stim      (stim),
        .valid     (valid),
        .done      (done),
        .state_dbg (state_dbg)
    );

    function automatic logic [BSIZE-1:0] f_ref(input int v);
        logic [BSIZE-1:0] b;
        b = v[BSIZE-1:0];
`ifdef PARAM_STIM_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [BSIZE-1:0] e_stim,
                              input logic e_valid, input logic e_done);
        check({tag, ".stim"},  32'(stim),  32'(e_stim));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".done"},  32'(done),  32'(e_done));
    endtask

    // Runs one full sequence. On entry the bench is between edges in an IDLE
    // cycle. On exit it is at the negedge of the IDLE cycle that follows DONE.
    // mode 0: pause is random with probability pct%. mode 1: pause is held for
    // three cycles, starting on the second cycle of value 1.
    task automatic do_seq(input int mode, input int pct);
        logic [BSIZE-1:0] exp_q[$];
        bit               pz_q[$];
        int               k;
        int               npause;
        int               vcount;
        bit               p;
        k      = 0;
        npause = 0;
        while (k < (LAST + 1) * HOLD) begin
            if (mode == 1) p = (k == HOLD + 1) && (npause < 3);
            else           p = ($urandom_range(99, 0) < pct);
            exp_q.push_back(f_ref(k / HOLD));
            pz_q.push_back(p);
            if (p) npause++;
            else   k++;
        end
        // Issue start. A simultaneous pause must not block it.
        start = 1'b1;
        pause = 1'($urandom_range(1, 0));
        @(posedge clock); #1;
        vcount = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            start = 1'($urandom_range(1, 0));
            pause = pz_q[i];
            @(negedge clock);
            if (valid === 1'b1) vcount++;
            check_outs($sformatf("run[%0d]", i), exp_q[i], 1'b1, 1'b0);
            @(posedge clock); #1;
        end
        check("valid_cycles", 32'(vcount), 32'((LAST + 1) * HOLD + npause));
        // DONE cycle. A start here must be ignored.
        start = 1'($urandom_range(1, 0));
        pause = 1'($urandom_range(1, 0));
        @(negedge clock);
        check_outs("done_cycle", f_ref(LAST), 1'b0, 1'b1);
        @(posedge clock); #1;
        start = 1'b0;
        pause = 1'($urandom_range(1, 0));
        @(negedge clock);
        check_outs("idle_after", f_ref(LAST), 1'b0, 1'b0);
        idle_stim = f_ref(LAST);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        idle_stim = '0;
        reset_n   = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        #1;
        check_outs("reset", '0, 1'b0, 1'b0);
        #21 reset_n = 1'b1;
        // IDLE with no start: outputs stay quiet even while pause toggles.
        for (int i = 0; i < 3; i++) begin
            pause = 1'($urandom_range(1, 0));
            @(negedge clock);
            check_outs("idle_init", '0, 1'b0, 1'b0);
        end
        // Run a plain sequence, then one with a directed pause.
        do_seq(0, 0);
        do_seq(1, 0);
        // Run back-to-back sequences with random pauses.
        do_seq(0, 20);
        do_seq(0, 50);
        do_seq(0, $urandom_range(70, 0));

        // Assert reset asynchronously in the middle of a run, while stim shows value 1.
        start = 1'b1;
        pause = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (HOLD) @(posedge clock);
        #2;
        check_outs("pre_reset", f_ref(1), 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", '0, 1'b0, 1'b0);
        @(negedge clock); #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pause = 1'($urandom_range(1, 0));
            @(negedge clock);
            check_outs("post_reset_idle", '0, 1'b0, 1'b0);
        end
        do_seq(0, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_stim_gen.md
# param_stim_gen

Parameterized stimulus sequencer that drives a width-parameterized input bus of a downstream consumer (e.g. an XOR/passthrough stage instantiated with a `bsize` override). On `start` it walks an output value from 0 up to a configured final value, holding each value for a fixed number of cycles, then signals completion. It replaces hand-written `#delay` stimulus in parameter-override diagnostics with a synthesizable, coverage-visible block whose output width tracks the consumer's `bsize`.

## Interface
Parameters:
- BSIZE, 2, output bus width; must equal the consumer's `bsize`; ≥1.
- HOLD, 5, cycles each value is held; ≥1.
- LAST, 2, final value emitted; 0 ≤ LAST ≤ 2^BSIZE-1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- pause  input  1  freeze the sequence while high; sampled only in RUN.
- stim  output  BSIZE  value driven to the consumer.
- valid  output  1  high while `stim` carries a sequence value.
- done  output  1  one-cycle pulse after the last hold completes.

## Operation
- State machine: IDLE, RUN, DONE.
- Internal state: value counter `cnt` (BSIZE bits); hold counter `hcnt` (ceil(log2(HOLD+1)) bits, minimum 1).
- IDLE: `valid`=0, `done`=0, `stim` holds its last value. If `start`=1, go to RUN with `cnt`=0 and `hcnt`=0.
- RUN: `valid`=1 and `stim` = f(`cnt`).
  - If `pause`=1: `cnt` and `hcnt` are frozen and `valid` stays 1.
  - Otherwise `hcnt` increments. When `hcnt`==HOLD-1:
    - if `cnt`==LAST, go to DONE;
    - else `cnt`+1 and `hcnt`=0.
  - `start` is ignored.
- DONE: lasts one cycle with `done`=1, `valid`=0, and `stim` frozen at f(LAST). Then go to IDLE unconditionally. `start` is ignored in DONE.
- f() is identity (binary). With the Configuration macro defined, f() is Gray code instead (see below).
- `cnt` never wraps. The LAST bound guarantees it stays in range.
- Reset asserted (asynchronously, at any point, including mid-RUN): state goes to IDLE, `cnt`=0, `hcnt`=0, `stim`=0, `valid`=0, `done`=0. The sequence restarts only on a new `start` after reset is released.

## Timing
- Reset values of all outputs: `stim`=0, `valid`=0, `done`=0.
- `start` high at edge N gives `valid`=1 and `stim`=f(0) after edge N (visible in cycle N+1).
- Each value is visible for exactly HOLD cycles, plus one extra cycle for each cycle `pause` is high during that value.
- With no pause, total `valid`-high time is (LAST+1)·HOLD cycles.
- `done` rises in the cycle immediately after the last `valid` cycle and lasts exactly 1 cycle.
- Earliest restart: `start` sampled in the cycle after DONE.
- `start` and `pause` both high in IDLE: `start` wins, and `pause` takes effect from the first RUN cycle.
- HOLD=1: `stim` changes every unpaused cycle.
- LAST=0: a single value is held for HOLD cycles, then DONE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `PARAM_STIM_GRAY_EN`.
- Defined: `stim` = `cnt` ^ (`cnt` >> 1). Registered so that it aligns with `valid` as above. Reset value is still 0.
- Undefined: `stim` = `cnt`. The Gray logic is not compiled in.
- State machine, counters and timing are identical in both builds.

## Test plan
- BSIZE=2, HOLD=5, LAST=2, binary build; `start` pulse at cycle 3 -> `stim` reads 0,1,2 for 5 cycles each (`valid`=1, cycles 4–18), `done`=1 at cycle 19 only, `stim` stays 2 afterwards.
- BSIZE=3, HOLD=1, LAST=7, `PARAM_STIM_GRAY_EN` defined -> `stim` = 0,1,3,2,6,7,5,4 on consecutive cycles, then `done` pulse; paired with a bsize=3 consumer, its output equals `stim` every cycle.
- BSIZE=2, HOLD=5, LAST=2; `pause` high for 3 cycles during the second cycle of value 1 -> value 1 lasts 8 cycles and `valid`-high time totals 18 cycles.
- Drop `reset_n` asynchronously mid-edge while `stim`=1 in RUN -> `stim`=0, `valid`=0, `done`=0 immediately; no activity until the next `start`.
- `start` held high continuously with LAST=0, HOLD=2 -> repeating pattern of 2 `valid` cycles, 1 `done` cycle, 1 IDLE cycle; `start` in RUN/DONE has no effect.
